music_sequencer: RTL and testbench

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

---
 rtl/music_sequencer_pkg.sv | 23 ++
 rtl/music_sequencer.sv | 166 ++++++++++++++++
 tb/tb_music_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/music_sequencer_pkg.sv
// Shared types and constants for the music sequencer: FSM states, ROM word
// field widths, end-of-song code and song slot geometry.
package music_sequencer_pkg;

  localparam int NOTE_W = 5;
  localparam int DUR_W  = 3;
  localparam int SLOT_W = 16;
  localparam int CNT_W  = 8;
  localparam logic [NOTE_W-1:0] END_CODE = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_PAUSED = 2'd3
  } state_t;

  // A duration code d means the note lasts 2^d beat ticks.
  function automatic logic [CNT_W-1:0] dur_ticks(input logic [DUR_W-1:0] d);
    return {{(CNT_W-1){1'b0}}, 1'b1} << d;
  endfunction

endpackage

// File: rtl/music_sequencer.sv
// Music sequencer: walks a song slot of an external combinational ROM, one
// {note, duration} word at a time, timing each note in beat ticks.
module music_sequencer
  import music_sequencer_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8,
  parameter logic [NOTE_W-1:0] END_CODE = music_sequencer_pkg::END_CODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic [7:0]        music_sel,
  input  logic              beat_tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              playing,
  output logic              song_end
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [NOTE_W-1:0]   r_note;
  logic [CNT_W-1:0]    r_dur;
  logic                r_note_valid;
  logic                r_playing;
  logic                r_song_end;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [NOTE_W-1:0]   w_note_nxt;
  logic [CNT_W-1:0]    w_dur_nxt;
  logic                w_song_end_nxt;
  logic                w_note_valid_nxt;
  logic                w_playing_nxt;

  logic [ADDR_W-1:0]   w_base;
  logic [NOTE_W-1:0]   w_rom_note;
  logic [DUR_W-1:0]    w_rom_dur;
  logic                w_slot_last;

  assign w_base      = ADDR_W'({music_sel, {SLOT_W{1'b0}}});
  assign w_rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur   = rom_data[DUR_W-1:0];
  // The last word of a slot has no successor; advancing past it ends the song.
  assign w_slot_last = &r_addr[SLOT_W-1:0];

  // State register and datapath registers, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_note       <= '0;
      r_dur        <= '0;
      r_note_valid <= 1'b0;
      r_playing    <= 1'b0;
      r_song_end   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_note       <= w_note_nxt;
      r_dur        <= w_dur_nxt;
      r_note_valid <= w_note_valid_nxt;
      r_playing    <= w_playing_nxt;
      r_song_end   <= w_song_end_nxt;
    end
  end

  // Next-state and datapath update; stop beats pause beats play, and a
  // winning stop/pause swallows any coincident beat tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_note_nxt     = r_note;
    w_dur_nxt      = r_dur;
    w_song_end_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (stop || pause) begin
          w_state_nxt = ST_IDLE;
        end else if (play) begin
          w_addr_nxt  = w_base;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rom_note == END_CODE) begin
          w_state_nxt    = ST_IDLE;
          w_song_end_nxt = 1'b1;
        end else begin
          w_note_nxt  = w_rom_note;
          w_dur_nxt   = dur_ticks(w_rom_dur);
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (pause) begin
          w_state_nxt = ST_PAUSED;
        end else if (beat_tick) begin
          w_dur_nxt = r_dur - 8'd1;
          if (r_dur == 8'd1) begin
            if (w_slot_last) begin
              w_state_nxt    = ST_IDLE;
              w_song_end_nxt = 1'b1;
            end else begin
              w_addr_nxt  = r_addr + ADDR_W'(1);
              w_state_nxt = ST_FETCH;
            end
          end else begin
            w_state_nxt = ST_PLAY;
          end
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PAUSED: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (pause) begin
          w_state_nxt = ST_PAUSED;
        end else if (play) begin
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = ST_PAUSED;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status flags follow the state being entered so they register in step with it.
  always_comb begin
    w_note_valid_nxt = 1'b0;
    w_playing_nxt    = 1'b0;
    case (w_state_nxt)
      ST_FETCH: w_playing_nxt = 1'b1;
      ST_PLAY: begin
        w_note_valid_nxt = 1'b1;
        w_playing_nxt    = 1'b1;
      end
      default: begin
        w_note_valid_nxt = 1'b0;
        w_playing_nxt    = 1'b0;
      end
    endcase
  end

  assign rom_addr   = r_addr;
  assign note       = r_note;
  assign note_valid = r_note_valid;
  assign playing    = r_playing;
  assign song_end   = r_song_end;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: a behavioural ROM plus note-level expectations
// (each word plays 2^d ticks, END or slot exhaustion ends the song).
module tb_music_sequencer;

  logic        clk = 1'b0;
  logic        reset, play, pause, stop, beat_tick;
  logic [7:0]  music_sel;
  logic [23:0] rom_addr;
  logic [7:0]  rom_data;
  logic [4:0]  note;
  logic        note_valid, playing, song_end;

  int          checks = 0;
  int          errors = 0;
  int          cycle_n = 0;
  bit          crossed = 1'b0;
  logic [7:0]  rnd_song [0:15];

  localparam logic [7:0] END_WORD = 8'hF8;

  music_sequencer dut (
    .clk(clk), .reset(reset), .play(play), .pause(pause), .stop(stop),
    .music_sel(music_sel), .beat_tick(beat_tick), .rom_addr(rom_addr),
    .rom_data(rom_data), .note(note), .note_valid(note_valid),
    .playing(playing), .song_end(song_end)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_word(input logic [23:0] a);
    logic [15:0] o;
    o = a[15:0];
    case (a[23:16])
      8'h00: case (o)
               16'd0:   return 8'h29;               // note 5, d=1
               16'd1:   return 8'h38;               // note 7, d=0
               default: return END_WORD;
             endcase
      8'h01: return {5'd1 + {1'b0, o[3:0]}, 3'd0};  // full slot, never END
      8'h03: case (o)
               16'd0:   return 8'h12;               // note 2, d=2
               16'd1:   return 8'h01;               // rest, d=1
               16'd2:   return 8'hF0;               // note 30, d=0
               default: return END_WORD;
             endcase
      8'h04: case (o)
               16'd0:   return 8'h4F;               // note 9, d=7
               16'd1:   return 8'h58;               // note 11, d=0
               default: return END_WORD;
             endcase
      8'h05: return (o < 16'd12) ? rnd_song[o[3:0]] : END_WORD;
      default: return END_WORD;
    endcase
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  always @(negedge clk) if (rom_addr == 24'h020000) crossed = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle_n++;
  endtask

  // Issue ticks per mode (0 every cycle, 1 every 4th, 2 random) until the note stops.
  task automatic count_ticks(input int mode, input int bound, output int cnt);
    bit bt;
    cnt = 0;
    for (int g = 0; g < bound; g++) begin
      case (mode)
        0:       bt = 1'b1;
        1:       bt = (cycle_n % 4 == 0);
        default: bt = ($urandom_range(0, 2) == 0);
      endcase
      beat_tick = bt;
      cyc();
      beat_tick = 1'b0;
      if (bt) cnt++;
      if (!note_valid) break;
    end
  endtask

  task automatic play_and_check(input logic [7:0] sel, input int n, input int mode, input bit ovf);
    logic [31:0] base;
    logic [7:0]  w;
    int          cnt;
    base = {8'h00, sel, 16'h0000};
    music_sel = sel;
    play = 1'b1;
    cyc();
    play = 1'b0;
    music_sel = sel ^ 8'h5A;
    chk("start_addr", {8'h00, rom_addr}, base);
    chk("start_playing", playing, 1);
    for (int k = 0; k < n; k++) begin
      w = rom_word(24'(base + k));
      cyc();
      chk("note", note, w[7:3]);
      chk("note_valid", note_valid, 1);
      count_ticks(mode, 4000, cnt);
      chk("note_len", cnt, 32'd1 << w[2:0]);
      if (!(ovf && k == n - 1)) begin
        chk("next_addr", {8'h00, rom_addr}, base + k + 1);
        chk("fetch_playing", playing, 1);
      end
    end
    if (!ovf) cyc();
    w = rom_word(24'(base + n - 1));
    chk("song_end", song_end, 1);
    chk("end_playing", playing, 0);
    chk("end_note", note, w[7:3]);
    chk("end_addr", {8'h00, rom_addr}, ovf ? base + n - 1 : base + n);
    cyc();
    chk("song_end_pulse", song_end, 0);
    chk("end_addr_hold", {8'h00, rom_addr}, ovf ? base + n - 1 : base + n);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0;
    beat_tick = 1'b0; music_sel = 8'h00;
    for (int i = 0; i < 12; i++)
      rnd_song[i] = {5'($urandom_range(0, 30)), 3'($urandom_range(0, 3))};
    for (int i = 12; i < 16; i++) rnd_song[i] = END_WORD;
    cyc();
    cyc();
    chk("rst_addr", rom_addr, 0);
    chk("rst_note", note, 0);
    chk("rst_valid", note_valid, 0);
    chk("rst_playing", playing, 0);
    chk("rst_song_end", song_end, 0);
    reset = 1'b0;
    cyc();

    // Basic song, a tick every 4 cycles.
    play_and_check(8'h00, 2, 1, 1'b0);
    // Slot 3 with random ticks; music_sel scrambled while playing.
    play_and_check(8'h03, 3, 2, 1'b0);

    // Long note paused mid-way, ticks ignored while paused.
    music_sel = 8'h04; play = 1'b1; cyc(); play = 1'b0;
    cyc();
    chk("p_note", note, 9);
    for (int i = 0; i < 10; i++) begin
      beat_tick = 1'b1; cyc();
    end
    beat_tick = 1'b0;
    chk("p_still_play", note_valid, 1);
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("p_paused_valid", note_valid, 0);
    chk("p_paused_playing", playing, 0);
    for (int i = 0; i < 50; i++) begin
      beat_tick = 1'b1; cyc();
    end
    beat_tick = 1'b0;
    chk("p_paused_hold", note_valid, 0);
    chk("p_paused_note", note, 9);
    chk("p_paused_addr", rom_addr, 24'h040000);
    play = 1'b1; cyc(); play = 1'b0;
    chk("p_resumed", note_valid, 1);
    count_ticks(0, 500, cnt);
    chk("p_remaining", cnt, 118);
    chk("p_fetch_addr", rom_addr, 24'h040001);
    // Pause raised during FETCH takes effect one cycle into PLAY.
    pause = 1'b1; cyc();
    chk("pf_play", note_valid, 1);
    chk("pf_note", note, 11);
    cyc(); pause = 1'b0;
    chk("pf_paused", note_valid, 0);
    play = 1'b1; cyc(); play = 1'b0;
    chk("pf_resumed", note_valid, 1);
    beat_tick = 1'b1; cyc(); beat_tick = 1'b0;
    chk("pf_fetch_addr", rom_addr, 24'h040002);
    cyc();
    chk("pf_song_end", song_end, 1);
    cyc();

    // All controls at once in PLAY: stop wins, no song_end.
    music_sel = 8'h03; play = 1'b1; cyc(); play = 1'b0;
    cyc();
    chk("s_in_play", note_valid, 1);
    stop = 1'b1; pause = 1'b1; play = 1'b1; beat_tick = 1'b1;
    cyc();
    stop = 1'b0; pause = 1'b0; play = 1'b0; beat_tick = 1'b0;
    chk("s_playing", playing, 0);
    chk("s_valid", note_valid, 0);
    chk("s_song_end", song_end, 0);
    chk("s_addr_hold", rom_addr, 24'h030000);
    cyc();
    chk("s_song_end2", song_end, 0);

    // Reset during FETCH, then during PLAY; restart from slot base.
    music_sel = 8'h03; play = 1'b1; cyc(); play = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rf_addr", rom_addr, 0);
    chk("rf_note", note, 0);
    chk("rf_playing", playing, 0);
    chk("rf_valid", note_valid, 0);
    music_sel = 8'h03; play = 1'b1; cyc(); play = 1'b0;
    chk("rf_restart", rom_addr, 24'h030000);
    cyc();
    beat_tick = 1'b1; cyc(); beat_tick = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rp_addr", rom_addr, 0);
    chk("rp_note", note, 0);
    chk("rp_valid", note_valid, 0);
    chk("rp_playing", playing, 0);
    chk("rp_song_end", song_end, 0);
    music_sel = 8'h03; play = 1'b1; cyc(); play = 1'b0;
    chk("rp_restart", rom_addr, 24'h030000);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Random song with random tick spacing.
    play_and_check(8'h05, 12, 2, 1'b0);

    // Full slot with no END word: slot exhaustion ends the song.
    play_and_check(8'h01, 65536, 0, 1'b1);
    for (int i = 0; i < 4; i++) cyc();
    chk("no_slot_cross", crossed, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
